// File: rtl/tutorial_aula_timer_arbiter.sv
// tutorial_aula_timer_arbiter
// Shares one interval timer (16-bit Avalon-MM slave) between NUM_REQ
// requesters that each need a one-shot delay. A round-robin arbiter picks one
// requester. This block then programs the timer period, clears stale status,
// starts the timer in one-shot mode with its interrupt enabled, waits for the
// irq and acknowledges it. If the owner drops its request while waiting, the
// timer is stopped and no done pulse is issued.
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   req            level request per requester
//   req_period     flat period vector, requester i uses bits [32i+31:32i]
//   done           one-cycle completion pulse to the owning requester
//   busy           high while a requester owns the timer
//   grant_idx      index of the current or last owner
//   tmr_address    timer register address
//   tmr_chipselect timer chipselect
//   tmr_write_n    timer write strobe, active-low
//   tmr_writedata  timer write data
//   tmr_irq        timer interrupt
module tutorial_aula_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_period,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic                    tmr_irq
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_PL    = 4'd1,
    S_WR_PH    = 4'd2,
    S_WR_CLR   = 4'd3,
    S_WR_CTL   = 4'd4,
    S_WAIT_IRQ = 4'd5,
    S_WR_ACK   = 4'd6,
    S_DONE     = 4'd7,
    S_CAN_STOP = 4'd8,
    S_CAN_CLR  = 4'd9
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [31:0]          period_q, period_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 cs_q, cs_d;
  logic                 wr_n_q, wr_n_d;
  logic [2:0]           addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;

  logic [IDX_W-1:0]     pick_s;
  logic [31:0]          pick_period_s;
  logic                 any_req_s;
  int                   best_dist_s;
  logic [IDX_W-1:0]     next_rr_s;

  // Round-robin pick: the set request at the smallest upward distance from rr.
  always_comb begin
    pick_s        = '0;
    pick_period_s = 32'd0;
    best_dist_s   = NUM_REQ;
    any_req_s     = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (((i - int'(rr_q) + NUM_REQ) % NUM_REQ) < best_dist_s)) begin
        best_dist_s   = (i - int'(rr_q) + NUM_REQ) % NUM_REQ;
        pick_s        = IDX_W'(i);
        pick_period_s = req_period[32*i +: 32];
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Pointer value after the current owner finishes, wrapping at NUM_REQ.
  always_comb begin
    if (grant_idx_q == IDX_W'(NUM_REQ - 1)) begin
      next_rr_s = '0;
    end else begin
      next_rr_s = grant_idx_q + IDX_W'(1);
    end
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    period_d    = period_q;
    rr_d        = rr_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          grant_idx_d = pick_s;
          period_d    = pick_period_s;
          // A zero period needs no timer at all: complete immediately.
          state_d     = (pick_period_s == 32'd0) ? S_DONE : S_WR_PL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_PL:  state_d = S_WR_PH;
      S_WR_PH:  state_d = S_WR_CLR;
      S_WR_CLR: state_d = S_WR_CTL;
      S_WR_CTL: state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        // irq takes priority over a request drop in the same cycle.
        if (tmr_irq) begin
          state_d = S_WR_ACK;
        end else if (!req[grant_idx_q]) begin
          state_d = S_CAN_STOP;
        end else begin
          state_d = S_WAIT_IRQ;
        end
      end
      S_WR_ACK:   state_d = S_DONE;
      S_DONE: begin
        rr_d    = next_rr_s;
        state_d = S_IDLE;
      end
      S_CAN_STOP: state_d = S_CAN_CLR;
      S_CAN_CLR: begin
        rr_d    = next_rr_s;
        state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop aligned with its state.
  always_comb begin
    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    addr_d  = 3'd0;
    wdata_d = 16'd0;
    case (state_d)
      S_WR_PL:    begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd2; wdata_d = period_d[15:0];  end
      S_WR_PH:    begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd3; wdata_d = period_d[31:16]; end
      S_WR_CLR:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd0; wdata_d = 16'h0000;        end
      S_WR_CTL:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0005;        end
      S_WR_ACK:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd0; wdata_d = 16'h0000;        end
      S_CAN_STOP: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008;        end
      S_CAN_CLR:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd0; wdata_d = 16'h0000;        end
      default:    begin cs_d = 1'b0; wr_n_d = 1'b1; addr_d = 3'd0; wdata_d = 16'h0000;        end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      done_d[i] = (state_d == S_DONE) && (grant_idx_d == IDX_W'(i));
    end
  end

  // State, arbitration and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      grant_idx_q <= '0;
      rr_q        <= '0;
      period_q    <= 32'd0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      wr_n_q      <= 1'b1;
      addr_q      <= 3'd0;
      wdata_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_q        <= rr_d;
      period_q    <= period_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      wr_n_q      <= wr_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign done           = done_q;
  assign busy           = busy_q;
  assign grant_idx      = grant_idx_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wr_n_q;
  assign tmr_writedata  = wdata_q;

endmodule

// File: doc/tutorial_aula_timer_arbiter.md
Name: tutorial_aula_timer_arbiter

Overview:
Shares the single system interval timer between NUM_REQ hardware requesters that each need a one-shot delay. Round-robin arbitration picks one requester at a time. The block drives the timer's 16-bit Avalon-MM slave port as a master: it loads the period, clears status, starts the timer in one-shot mode with interrupt enabled, waits for irq, then acknowledges it. It sits beside the CPU; the timer's s1 port is dedicated to this master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of requester index; must equal ceil(log2(NUM_REQ))

Ports:
clk  input  1  system clock
reset_n  input  1  reset; synchronous, active-low
req  input  NUM_REQ  level request per requester; held high until done or cancel
req_period  input  32*NUM_REQ  flat period vector; requester i uses bits [32i+31:32i]
done  output  NUM_REQ  one-cycle completion pulse to the owning requester
busy  output  1  high while any requester owns the timer
grant_idx  output  IDX_W  index of the current or last owner
tmr_address  output  3  timer register address
tmr_chipselect  output  1  timer chipselect
tmr_write_n  output  1  timer write strobe, active-low
tmr_writedata  output  16  timer write data
tmr_irq  input  1  timer interrupt

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; done=0, busy=0, grant_idx=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0; rr pointer=0. Reset mid-sequence abandons the sequence without a stop write. The timer is reset by the same reset_n.
- Every timer access is a single-cycle write: chipselect=1 and write_n=0 for exactly one cycle, with address and data registered. The timer has no waitrequest. No reads are issued. Outside write states, chipselect=0 and write_n=1.
- States and transitions:
  - IDLE: if any req bit is set, grant the first set bit scanning upward from the rr pointer with wrap. Latch grant_idx and the 32-bit period as P. busy goes high the next cycle. If P==0, go to DONE. Otherwise go to WR_PL.
  - WR_PL: write address 2, data P[15:0]. Go to WR_PH.
  - WR_PH: write address 3, data P[31:16]. Go to WR_CLR. The timer reloads and stops on period writes.
  - WR_CLR: write address 0, data 0, which clears any stale timeout. Go to WR_CTL.
  - WR_CTL: write address 1, data 16'h0005 (START|ITO, continuous=0). Go to WAIT_IRQ.
  - WAIT_IRQ: if tmr_irq=1, go to WR_ACK. If req[grant_idx]=0, go to CANCEL. If both hold in the same cycle, irq wins.
  - WR_ACK: write address 0, data 0. Go to DONE.
  - DONE: done[grant_idx]=1 for this one cycle. rr pointer = grant_idx+1 modulo NUM_REQ. Go to IDLE. busy drops the next cycle.
  - CANCEL: write address 1, data 16'h0008 (STOP, ITO=0). Then write address 0, data 0. No done pulse. rr pointer advances as in DONE. Return to IDLE.
- Latency:
  - First timer write (WR_PL) occurs 1 cycle after the grant cycle.
  - Start write occurs 4 cycles after grant.
  - Timer expiry: P+1 cycles after the start write plus timer-internal delays.
  - done pulses 2 cycles after tmr_irq is first seen high in WAIT_IRQ.
- req deassertion outside WAIT_IRQ while owned is ignored until WAIT_IRQ is reached, which then cancels. req_period changes after the grant cycle have no effect.
- New requests arriving during a sequence wait; no preemption. tmr_irq outside WAIT_IRQ is ignored.
- Fairness: a requester that re-asserts req immediately after done is served only after all other pending requesters.

Test Plan:
- Single request: req[1]=1, period=32'h0001_0009. Expect writes (2,16'h0009), (3,16'h0001), (0,0), (1,16'h0005) on 4 consecutive cycles starting 1 cycle after grant. Model irq after 10 cycles. Expect write (0,0), then done[1] as a single pulse, grant_idx=1, busy cleared.
- Contention: req=4'b1111 continuously held, period 5 each. Expect grant order 0,1,2,3,0, with exactly one done per sequence and never two owners.
- Zero period: req[2]=1, period=0. Expect no timer writes, done[2] pulse 1 cycle after grant, rr pointer=3.
- Cancel: req[0] dropped during WAIT_IRQ. Expect writes (1,16'h0008) then (0,0), no done pulse, return to IDLE. Simultaneous drop+irq: expect WR_ACK path and a done pulse.
- Reset mid-sequence: assert reset_n=0 during WR_PH. Expect all outputs at reset values on the next edge. After release with req[3]=1, expect a fresh sequence for requester 3 from WR_PL.
- Spurious irq: tmr_irq high while IDLE or in WR_CTL. Expect no done and the sequence unaffected.
